// File: rtl/bip_control.sv
// BIP processor control unit: fetch/decode FSM driving datapath selects and data-memory strobes.
// Optional cycle counter enabled with `define BIP_CLK_COUNT_EN; otherwise o_clk_count is tied to 0.
//
// state  | meaning
// FETCH  | PC presented to program memory
// DECODE | instruction word latched into IR; HLT diverts to HALT
// EXEC   | data-memory read issued for LD/ADD/SUB
// WB     | accumulator / memory write strobes, PC advances
// HALT   | parked until reset
module bip_control #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_OPCODE      = 5,
    parameter int NB_OPERAND     = 11,
    parameter int NB_PC          = 11,
    parameter int NB_DATA_ADDR   = 10,
    parameter int NB_SEL_A       = 2,
    parameter int NB_CLK_COUNT   = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic [NB_PC-1:0]          o_pc_addr,
    output logic [NB_DATA_ADDR-1:0]   o_data_addr,
    output logic                      o_rd_mem,
    output logic                      o_wr_mem,
    output logic [NB_OPERAND-1:0]     o_operand,
    output logic [NB_SEL_A-1:0]       o_sel_a,
    output logic                      o_sel_b,
    output logic                      o_op_code,
    output logic                      o_wr_acc,
    output logic                      o_halted,
    output logic [NB_CLK_COUNT-1:0]   o_clk_count
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB     = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
    localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
    localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
    localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
    localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
    localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
    localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
    localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

    localparam logic [NB_SEL_A-1:0] SEL_A_MEM = 2'b00;
    localparam logic [NB_SEL_A-1:0] SEL_A_IMM = 2'b01;
    localparam logic [NB_SEL_A-1:0] SEL_A_ALU = 2'b10;

    logic [2:0]                state_q, state_d;
    logic [NB_PC-1:0]          pc_q, pc_d;
    logic [NB_INSTRUCTION-1:0] ir_q, ir_d;
    logic [NB_OPCODE-1:0]      ir_opcode;
    logic [NB_OPCODE-1:0]      fetch_opcode;

    assign ir_opcode    = ir_q[NB_INSTRUCTION-1 -: NB_OPCODE];
    assign fetch_opcode = i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (i_enable) begin
            case (state_q)
                ST_FETCH: state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d    = i_instruction;
                    state_d = (fetch_opcode == OP_HLT) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: state_d = ST_WB;
                ST_WB: begin
                    pc_d    = pc_q + NB_PC'(1);
                    state_d = ST_FETCH;
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Strobes are pure decodes of state and IR, so an async reset kills them immediately.
    always_comb begin
        o_rd_mem  = 1'b0;
        o_wr_mem  = 1'b0;
        o_wr_acc  = 1'b0;
        o_sel_a   = SEL_A_MEM;
        o_sel_b   = 1'b0;
        o_op_code = 1'b0;
        case (state_q)
            ST_EXEC: begin
                if (ir_opcode == OP_LD || ir_opcode == OP_ADD || ir_opcode == OP_SUB)
                    o_rd_mem = i_enable;
            end
            ST_WB: begin
                case (ir_opcode)
                    OP_STO: o_wr_mem = i_enable;
                    OP_LD: begin
                        o_wr_acc = i_enable;
                        o_sel_a  = SEL_A_MEM;
                    end
                    OP_LDI: begin
                        o_wr_acc = i_enable;
                        o_sel_a  = SEL_A_IMM;
                    end
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        o_wr_acc  = i_enable;
                        o_sel_a   = SEL_A_ALU;
                        o_sel_b   = ir_opcode[0];
                        o_op_code = (ir_opcode == OP_ADD || ir_opcode == OP_ADDI);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign o_pc_addr   = pc_q;
    assign o_data_addr = ir_q[NB_DATA_ADDR-1:0];
    assign o_operand   = ir_q[NB_OPERAND-1:0];
    assign o_halted    = (state_q == ST_HALT);

`ifdef BIP_CLK_COUNT_EN
    logic [NB_CLK_COUNT-1:0] clk_count_q, clk_count_d;

    always_comb begin
        clk_count_d = clk_count_q;
        if (i_enable && state_q != ST_HALT && clk_count_q != '1)
            clk_count_d = clk_count_q + NB_CLK_COUNT'(1);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            clk_count_q <= '0;
        else
            clk_count_q <= clk_count_d;
    end

    assign o_clk_count = clk_count_q;
`else
    assign o_clk_count = '0;
`endif

endmodule
